// File: rtl/spi_adc_pkg.sv
// Shared types and defaults for the SPI ADC arbiter.
package spi_adc_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_CAPTURE,
        S_DONE
    } state_e;

    // Default number of clk cycles allowed from the start pulse to cs_n falling
    localparam int unsigned TO_CYC_DEF = 64;

endpackage

// File: rtl/spi_adc_arbiter_if.sv
// Requester/ADC-side bus of the SPI ADC arbiter.
interface spi_adc_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              adc_n_start;
    logic              adc_cs_n;
    logic [DATA_W-1:0] adc_data;

    // Environment side: requesters and the SPI ADC master
    modport master (
        output req, adc_cs_n, adc_data,
        input  grant, busy, done, done_id, rdata, err, adc_n_start
    );

    // Arbiter side
    modport slave (
        input  req, adc_cs_n, adc_data,
        output grant, busy, done, done_id, rdata, err, adc_n_start
    );
endinterface

// File: rtl/spi_adc_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    // Scan NREQ positions starting at ptr; the first active one wins
    always_comb begin
        logic          found;
        int unsigned   pos;
        logic [IDW-1:0] p;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        p       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr_i) + i) % NREQ;
            p   = IDW'(pos);
            if (!found && req_i[p]) begin
                found      = 1'b1;
                grant_o[p] = 1'b1;
                idx_o      = p;
            end
        end
    end

endmodule

// File: rtl/spi_adc_arbiter.sv
// Round-robin arbiter sharing one SPI ADC master among NREQ requesters.
module spi_adc_arbiter
    import spi_adc_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TO_CYC = TO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    spi_adc_arbiter_if.slave  bus
);

    localparam int unsigned     IDW     = $clog2(NREQ);
    localparam int unsigned     CNTW    = $clog2(TO_CYC + 1);
    // Counter value in the last WAIT_LOW cycle before the timeout fires;
    // the counter is 0 in START and increments once per cycle after it.
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TO_CYC - 1);
    localparam logic [IDW-1:0]  ID_MAX  = IDW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   pick_grant;
    logic [IDW-1:0]    pick_idx;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_START;
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                state_d = S_WAIT_LOW;
                cnt_d   = cnt_q + CNTW'(1);
            end
            S_WAIT_LOW: begin
                if (!bus.adc_cs_n) begin
                    state_d = S_WAIT_HIGH;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_DONE;
                    grant_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (bus.adc_cs_n) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_d = bus.adc_data;
                err_d   = 1'b0;
                grant_d = '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (idx_q == ID_MAX) ? '0 : idx_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.done_id     = idx_q;
    assign bus.rdata       = rdata_q;
    assign bus.err         = (state_q == S_DONE) && err_q;
    assign bus.adc_n_start = (state_q != S_START);

endmodule

// File: doc/spi_adc_arbiter.md
SPI_ADC_ARBITER -- requirements
Module: spi_adc_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the ADC result width.
REQ-003 SHALL have parameter TO_CYC, default 64, meaning the clk cycles allowed from start pulse to cs_n falling.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port req, input, NREQ, one level request bit per requester.
REQ-007 SHALL have port grant, output, NREQ, one-hot grant held for the whole transaction.
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-009 SHALL have port done, output, 1, a one-cycle completion strobe.
REQ-010 SHALL have port done_id, output, clog2(NREQ), the index of the requester served.
REQ-011 SHALL have port rdata, output, DATA_W, the captured ADC result.
REQ-012 SHALL have port err, output, 1, qualified by done; high means timeout and rdata is unchanged.
REQ-013 SHALL have port adc_n_start, output, 1, active-low start pulse to the SPI ADC master.
REQ-014 SHALL have port adc_cs_n, input, 1, chip-select from the SPI ADC master on clk; no synchroniser.
REQ-015 SHALL have port adc_data, input, DATA_W, the result bus of the SPI ADC master.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT_LOW, WAIT_HIGH, CAPTURE, DONE.
REQ-017 In IDLE with req!=0, SHALL on the next edge enter START with grant set one-hot to the round-robin winner.
REQ-018 Round-robin SHALL search from index ptr upward with wrap-around; after each DONE, ptr = served index + 1 mod NREQ.
REQ-019 START SHALL last exactly one cycle with adc_n_start=0, then enter WAIT_LOW; adc_n_start=1 in every other state.
REQ-020 WAIT_LOW SHALL enter WAIT_HIGH on the first cycle with adc_cs_n=0.
REQ-021 WAIT_LOW SHALL enter DONE with err=1 if adc_cs_n stays 1 for TO_CYC cycles after START.
REQ-022 WAIT_HIGH SHALL enter CAPTURE on the first cycle with adc_cs_n=1; there is no timeout in WAIT_HIGH.
REQ-023 CAPTURE SHALL register adc_data into rdata, last one cycle, then enter DONE.
REQ-024 DONE SHALL last one cycle with done=1 and valid done_id/err, deassert grant that cycle, then return to IDLE.
REQ-025 rdata SHALL hold its value until the next successful CAPTURE.
REQ-026 A requester that drops req mid-transaction SHALL NOT abort it; the result is still delivered.
REQ-027 A requester holding req continuously SHALL be re-served only after every other active requester, with minimum 1 IDLE cycle between transactions.
REQ-028 Changes on req outside IDLE SHALL be ignored.

Reset
REQ-029 On rst: state IDLE, ptr=0, grant=0, busy=0, done=0, done_id=0, rdata=0, err=0, adc_n_start=1.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no done strobe.

Structure
REQ-031 The FSM state encoding and TO_CYC default SHALL live in shared package spi_adc_pkg.
REQ-032 The round-robin picker SHALL be sub-module rr_pick (inputs req and ptr; outputs one-hot grant and index).
REQ-033 The timeout counter SHALL be clog2(TO_CYC+1) bits and cleared on entry to START.

Verification
REQ-034 Single request: req=0001, slave data 0xC5 -> one adc_n_start low cycle, grant=0001 until done, done_id=0, rdata=0xC5, err=0.
REQ-035 Contention: req=1111 held, data 0xC5..0xC8 -> done_id sequence 0,1,2,3, then 0, each rdata matching the slave data.
REQ-036 Timeout: slave held in reset so cs_n stays 1 -> done with err=1 exactly 64 cycles after START, rdata unchanged.
REQ-037 Request drop: req=0100 drops during WAIT_HIGH -> transaction completes with done_id=2.
REQ-038 Reset mid-op: rst during WAIT_HIGH -> adc_n_start=1, grant=0, no done, ptr=0; next req=0010 is served normally.
